unified_mem_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch (IF) port and data-memory (MEM stage) port.
- Per access: arbitrates, issues one memory command, waits MEM_LAT cycles, then returns data with a one-cycle ack.
- Generates the stall signals that freeze the pipeline registers while a requester is waiting.
- Sits between the datapath's fetch/load-store logic and the shared memory macro.

---
 rtl/unified_mem_arbiter_pkg.sv | 11 +
 rtl/arb_wait_counter.sv | 27 ++
 rtl/unified_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Types and defaults shared by the unified memory arbiter and the datapath memories.
package unified_mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;

    typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} ownerT;

endpackage

// File: rtl/arb_wait_counter.sv
// Down-counter that times the fixed memory latency between the issue cycle and read-data capture.
module arb_wait_counter #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int CNT_W = $clog2(MEM_LAT) + 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(MEM_LAT - 1);
        end else if (dec && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported, fixed-latency memory between instruction fetch and data access,
// one command per grant, with stall outputs that freeze the waiting pipeline stage.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    stateT               state;
    ownerT               owner;
    logic                isWrite;
    logic [STARVE_W-1:0] starveCnt;
    logic                waitZero;
    logic                grantDm;

    // Data wins a contested cycle unless fetch has already lost STARVE_MAX times in a row.
    assign grantDm = dm_req && !(if_req && starveCnt == STARVE_W'(STARVE_MAX));

    arb_wait_counter #(.MEM_LAT(MEM_LAT)) waitCounter (
        .clk  (clk),
        .rst  (rst),
        .load (state == ISSUE),
        .dec  (state == WAIT),
        .zero (waitZero)
    );

    // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: data registers are reset as well; they drive ports that must read 0 after reset.
            state     <= IDLE;
            owner     <= OWN_IF;
            isWrite   <= 1'b0;
            starveCnt <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        if (grantDm) begin
                            owner     <= OWN_DM;
                            isWrite   <= dm_we;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            if (if_req && starveCnt != STARVE_W'(STARVE_MAX))
                                starveCnt <= starveCnt + STARVE_W'(1);
                        end else begin
                            owner     <= OWN_IF;
                            isWrite   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            starveCnt <= '0;
                        end
                        mem_en <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (waitZero) begin
                        if (owner == OWN_DM) begin
                            dm_ack <= 1'b1;
                            if (!isWrite) dm_rdata <= mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-count reference model of the grant/latency rules.
module tb_unified_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    logic          stall_mem;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    // Memory macro: contents in an associative array, read data delayed LAT cycles after mem_en,
    // random garbage on the bus in every other cycle.
    logic [DW-1:0] memArr [logic [AW-1:0]];
    logic [DW-1:0] pipe [LAT];
    assign mem_rdata = pipe[LAT-1];

    function automatic logic [DW-1:0] initWord(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) memArr[mem_addr] = mem_wdata;
        if (mem_en && !mem_we)
            pipe[0] <= memArr.exists(mem_addr) ? memArr[mem_addr] : initWord(mem_addr);
        else
            pipe[0] <= $urandom;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    // Reference model: tracks the current grant by its arbitration cycle number only.
    logic [DW-1:0] refMem [logic [AW-1:0]];
    int            cyc;
    int            grantCyc;
    bit            active;
    bit            curDm;
    bit            curWe;
    logic [AW-1:0] curAddr;
    logic [DW-1:0] curWdata;
    int            starve;
    bit            expMemEn, expMemWe, expIfAck, expDmAck, expBusy;
    logic [AW-1:0] expMemAddr;
    logic [DW-1:0] expMemWdata, expIfRdata, expDmRdata;

    task automatic model_reset();
        active      = 1'b0;
        grantCyc    = -100;
        starve      = 0;
        cyc         = 0;
        expIfRdata  = '0;
        expDmRdata  = '0;
        expMemAddr  = '0;
        expMemWdata = '0;
    endtask

    task automatic model_expect();
        logic [DW-1:0] rd;
        expMemEn = active && (cyc == grantCyc + 1);
        expMemWe = expMemEn && curWe;
        if (expMemEn) begin
            expMemAddr = curAddr;
            if (curDm) expMemWdata = curWdata;
        end
        expIfAck = active && !curDm && (cyc == grantCyc + LAT + 2);
        expDmAck = active && curDm && (cyc == grantCyc + LAT + 2);
        if ((expIfAck || expDmAck) && !curWe) begin
            rd = refMem.exists(curAddr) ? refMem[curAddr] : initWord(curAddr);
            if (curDm) expDmRdata = rd;
            else expIfRdata = rd;
        end
        expBusy = active && (cyc > grantCyc) && (cyc <= grantCyc + LAT + 2);
    endtask

    task automatic model_arbitrate();
        bit pickDm;
        if (!active || cyc > grantCyc + LAT + 2) begin
            active = 1'b0;
            if (if_req || dm_req) begin
                pickDm = dm_req && !(if_req && starve == SMAX);
                if (pickDm) begin
                    if (if_req && starve < SMAX) starve++;
                    curWe = dm_we; curAddr = dm_addr; curWdata = dm_wdata;
                    if (dm_we) refMem[dm_addr] = dm_wdata;
                end else begin
                    starve = 0;
                    curWe = 1'b0; curAddr = if_addr;
                end
                curDm    = pickDm;
                active   = 1'b1;
                grantCyc = cyc;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_en, mem_we, if_ack, dm_ack, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {mem_en, mem_we, if_ack, dm_ack, busy});
        end
        checks++;
        if (if_rdata !== '0 || dm_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata got if=%h dm=%h want 0", if_rdata, dm_rdata);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || mem_en !== 1'b0 || stall_if !== 1'b0 || stall_mem !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet got busy=%b en=%b sif=%b smem=%b want 0", busy, mem_en, stall_if, stall_mem);
            end
        end
    endtask

    task automatic test_if_read();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (mem_en !== (c == 1)) begin
                errors++; $display("FAIL if_read_mem_en c=%0d got %b want %b", c, mem_en, c == 1);
            end
            checks++;
            if (if_ack !== (c == 4) || dm_ack !== 1'b0) begin
                errors++; $display("FAIL if_read_ack c=%0d got if=%b dm=%b want if=%b dm=0", c, if_ack, dm_ack, c == 4);
            end
            checks++;
            if (stall_if !== (c < 4)) begin
                errors++; $display("FAIL if_read_stall c=%0d got %b want %b", c, stall_if, c < 4);
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
                    errors++; $display("FAIL if_read_cmd got addr=%h we=%b want 40/0", mem_addr, mem_we);
                end
            end
            if (c == 4) begin
                checks++;
                if (if_rdata !== 32'h8C01_0004) begin
                    errors++; $display("FAIL if_read_data got %h want 8c010004", if_rdata);
                end
                if_req = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0;
        for (int c = 0; c < 12; c++) begin
            #1;
            checks++;
            if (mem_en !== (c == 1 || c == 6)) begin
                errors++; $display("FAIL b2b_mem_en c=%0d got %b want %b", c, mem_en, c == 1 || c == 6);
            end
            checks++;
            if (dm_ack !== (c == 4 || c == 9) || if_ack !== 1'b0) begin
                errors++; $display("FAIL b2b_ack c=%0d got dm=%b if=%b want dm=%b", c, dm_ack, if_ack, c == 4 || c == 9);
            end
            if (c == 6) begin
                checks++;
                if (mem_addr !== 32'h4) begin
                    errors++; $display("FAIL b2b_addr2 got %h want 4", mem_addr);
                end
            end
            if (c == 4) begin
                checks++;
                if (dm_rdata !== initWord(32'h0)) begin
                    errors++; $display("FAIL b2b_data1 got %h want %h", dm_rdata, initWord(32'h0));
                end
                dm_addr = 32'h4;
            end
            if (c == 9) begin
                checks++;
                if (dm_rdata !== initWord(32'h4)) begin
                    errors++; $display("FAIL b2b_data2 got %h want %h", dm_rdata, initWord(32'h4));
                end
                dm_req = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_dm_write();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (mem_en !== (c == 1) || mem_we !== (c == 1)) begin
                errors++; $display("FAIL wr_strobe c=%0d got en=%b we=%b want %b", c, mem_en, mem_we, c == 1);
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
                    errors++; $display("FAIL wr_cmd got addr=%h wdata=%h want 100/deadbeef", mem_addr, mem_wdata);
                end
            end
            checks++;
            if (dm_ack !== (c == 4)) begin
                errors++; $display("FAIL wr_ack c=%0d got %b want %b", c, dm_ack, c == 4);
            end
            checks++;
            if (dm_rdata !== initWord(32'h4)) begin
                errors++; $display("FAIL wr_rdata_hold c=%0d got %h want %h", c, dm_rdata, initWord(32'h4));
            end
            if (c == 4) begin
                dm_req = 1'b0; dm_we = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_simultaneous();
        bit expEn, expIf, expDm;
        apply_reset();
        if_req = 1'b1; if_addr = 32'hA00;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hB00;
        for (int c = 0; c < 30; c++) begin
            #1;
            expEn = (c % 5 == 1);
            expIf = (c == 14 || c == 29);
            expDm = (c == 4 || c == 9 || c == 19 || c == 24);
            checks++;
            if (mem_en !== expEn) begin
                errors++; $display("FAIL sim_mem_en c=%0d got %b want %b", c, mem_en, expEn);
            end
            if (expEn) begin
                checks++;
                if (mem_addr !== ((c == 11 || c == 26) ? 32'hA00 : 32'hB00)) begin
                    errors++; $display("FAIL sim_grant_order c=%0d got addr=%h", c, mem_addr);
                end
            end
            checks++;
            if (if_ack !== expIf || dm_ack !== expDm) begin
                errors++; $display("FAIL sim_ack c=%0d got if=%b dm=%b want if=%b dm=%b", c, if_ack, dm_ack, expIf, expDm);
            end
            if (c == 29) begin
                if_req = 1'b0; dm_req = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_drop_req();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) dm_req = 1'b0;
            #1;
            checks++;
            if (stall_mem !== (c == 0)) begin
                errors++; $display("FAIL drop_stall c=%0d got %b want %b", c, stall_mem, c == 0);
            end
            checks++;
            if (dm_ack !== (c == 4)) begin
                errors++; $display("FAIL drop_ack c=%0d got %b want %b", c, dm_ack, c == 4);
            end
            if (c == 4) begin
                checks++;
                if (dm_rdata !== initWord(32'h200)) begin
                    errors++; $display("FAIL drop_data got %h want %h", dm_rdata, initWord(32'h200));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit expEn;
        apply_reset();
        if_req = 1'b1; if_addr = 32'hA00;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hB00;
        for (int c = 0; c < 19; c++) begin
            if (c == 7) rst = 1'b0;
            if (c == 8) rst = 1'b1;
            #1;
            if (c == 7) begin
                checks++;
                if ({busy, mem_en, mem_we, if_ack, dm_ack} !== 5'b0 || dm_rdata !== '0 || mem_addr !== '0) begin
                    errors++;
                    $display("FAIL midrst_outputs got busy=%b en=%b ack=%b%b dm_rdata=%h addr=%h want 0",
                             busy, mem_en, if_ack, dm_ack, dm_rdata, mem_addr);
                end
            end
            expEn = (c == 1 || c == 6 || c == 9 || c == 14);
            checks++;
            if (mem_en !== expEn) begin
                errors++; $display("FAIL midrst_mem_en c=%0d got %b want %b", c, mem_en, expEn);
            end
            if (c == 9 || c == 14) begin
                checks++;
                if (mem_addr !== ((c == 9) ? 32'hB00 : 32'hA00)) begin
                    errors++; $display("FAIL midrst_grant c=%0d got %h", c, mem_addr);
                end
            end
            checks++;
            if (dm_ack !== (c == 4 || c == 12) || if_ack !== (c == 17)) begin
                errors++; $display("FAIL midrst_ack c=%0d got if=%b dm=%b", c, if_ack, dm_ack);
            end
            if (c == 12) dm_req = 1'b0;
            if (c == 17) begin
                checks++;
                if (if_rdata !== initWord(32'hA00)) begin
                    errors++; $display("FAIL midrst_if_data got %h want %h", if_rdata, initWord(32'hA00));
                end
                if_req = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random(input int ncyc);
        int ifGap = 0;
        int dmGap = 0;
        apply_reset();
        model_reset();
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            cyc++;
            model_expect();
            checks++;
            if (mem_en !== expMemEn || mem_we !== expMemWe) begin
                errors++; $display("FAIL rnd_strobe cyc=%0d got en=%b we=%b want en=%b we=%b", cyc, mem_en, mem_we, expMemEn, expMemWe);
            end
            if (expMemEn) begin
                checks++;
                if (mem_addr !== expMemAddr || (expMemWe && mem_wdata !== expMemWdata)) begin
                    errors++; $display("FAIL rnd_cmd cyc=%0d got %h/%h want %h/%h", cyc, mem_addr, mem_wdata, expMemAddr, expMemWdata);
                end
            end
            checks++;
            if (if_ack !== expIfAck || dm_ack !== expDmAck) begin
                errors++; $display("FAIL rnd_ack cyc=%0d got if=%b dm=%b want if=%b dm=%b", cyc, if_ack, dm_ack, expIfAck, expDmAck);
            end
            checks++;
            if (if_rdata !== expIfRdata || dm_rdata !== expDmRdata) begin
                errors++; $display("FAIL rnd_rdata cyc=%0d got if=%h dm=%h want if=%h dm=%h", cyc, if_rdata, dm_rdata, expIfRdata, expDmRdata);
            end
            checks++;
            if (busy !== expBusy) begin
                errors++; $display("FAIL rnd_busy cyc=%0d got %b want %b", cyc, busy, expBusy);
            end
            // Requesters: hold until ack, then either chain a new access or go quiet for a while.
            if (if_req && if_ack) begin
                if ($urandom_range(1) == 1) if_addr = AW'($urandom_range(15)) << 2;
                else begin if_req = 1'b0; ifGap = $urandom_range(3); end
            end else if (!if_req) begin
                if (ifGap == 0) begin if_req = 1'b1; if_addr = AW'($urandom_range(15)) << 2; end
                else ifGap--;
            end
            if (dm_req && dm_ack) begin
                if ($urandom_range(1) == 1) begin
                    dm_addr = AW'($urandom_range(15)) << 2; dm_we = 1'($urandom_range(1)); dm_wdata = $urandom;
                end else begin dm_req = 1'b0; dmGap = $urandom_range(3); end
            end else if (!dm_req) begin
                if (dmGap == 0) begin
                    dm_req = 1'b1; dm_addr = AW'($urandom_range(15)) << 2;
                    dm_we = 1'($urandom_range(1)); dm_wdata = $urandom;
                end else dmGap--;
            end
            #1;
            checks++;
            if (stall_if !== (if_req && !expIfAck) || stall_mem !== (dm_req && !expDmAck)) begin
                errors++; $display("FAIL rnd_stall cyc=%0d got if=%b mem=%b", cyc, stall_if, stall_mem);
            end
            model_arbitrate();
        end
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    initial begin
        memArr[32'h40] = 32'h8C01_0004;
        test_reset();
        test_if_read();
        test_back_to_back();
        test_dm_write();
        test_simultaneous();
        test_drop_req();
        test_reset_mid_wait();
        test_random(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
